// File: rtl/riscv_lsu.sv
// riscv_lsu: memory-stage load/store unit for the RV32I pipeline.
// Formats loads/stores, runs the req/ack data-memory handshake and stalls the pipeline until it completes.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_ctrl_mem_rd_enM,
  input  logic              i_ctrl_mem_wr_enM,
  input  logic [2:0]        i_funct3M,
  input  logic [`XLEN-1:0]  i_alu_resultM,
  input  logic [`XLEN-1:0]  i_rs2_dataM,
  output logic              o_dmem_req,
  output logic              o_dmem_wr,
  output logic [`XLEN-1:0]  o_dmem_addr,
  output logic [`XLEN-1:0]  o_dmem_wdata,
  output logic [3:0]        o_dmem_byte_en,
  input  logic              i_dmem_ack,
  input  logic [`XLEN-1:0]  i_dmem_rdata,
  output logic              o_stallM,
  output logic [`XLEN-1:0]  o_mem_readdataM,
  output logic              o_faultM,
  output logic [1:0]        o_fault_codeM
);
  localparam int unsigned XW    = `XLEN;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_ILLEGAL  = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XW-1:0]     addr_q, addr_d;
  logic [XW-1:0]     wdata_q, wdata_d;
  logic [XW-1:0]     rdata_q, rdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic              wr_q, wr_d;

  logic              access, illegal, misaligned, ld_f3_ok, st_f3_ok, timeout;
  logic [3:0]        st_be;
  logic [XW-1:0]     st_wdata, ld_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // Access classification; illegal outranks misaligned in the FSM below.
  always_comb begin
    access     = i_ctrl_mem_rd_enM | i_ctrl_mem_wr_enM;
    ld_f3_ok   = (i_funct3M != 3'b011) && (i_funct3M[2:1] != 2'b11);
    st_f3_ok   = (i_funct3M[2] == 1'b0) && (i_funct3M[1:0] != 2'b11);
    illegal    = (i_ctrl_mem_rd_enM & i_ctrl_mem_wr_enM) |
                 (i_ctrl_mem_rd_enM & ~ld_f3_ok) |
                 (i_ctrl_mem_wr_enM & ~st_f3_ok);
    misaligned = ((i_funct3M[1:0] == 2'b01) & i_alu_resultM[0]) |
                 ((i_funct3M[1:0] == 2'b10) & (i_alu_resultM[1:0] != 2'b00));
  end

  // Store lane formatting from the live execute-stage operands.
  always_comb begin
    case (i_funct3M[1:0])
      2'b00: begin
        st_be    = 4'b0001 << i_alu_resultM[1:0];
        st_wdata = {4{i_rs2_dataM[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {i_alu_resultM[1], 1'b0};
        st_wdata = {2{i_rs2_dataM[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = i_rs2_dataM;
      end
    endcase
  end

  // Load extraction uses the latched address offset and funct3.
  always_comb begin
    ld_byte = 8'(i_dmem_rdata >> {addr_q[1:0], 3'b000});
    ld_half = 16'(i_dmem_rdata >> {addr_q[1], 4'b0000});
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  assign timeout = (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    be_d            = be_q;
    f3_d            = f3_q;
    wr_d            = wr_q;
    o_stallM        = 1'b0;
    o_faultM        = 1'b0;
    o_fault_codeM   = 2'b00;
    o_mem_readdataM = rdata_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            o_faultM      = 1'b1;
            o_fault_codeM = FC_ILLEGAL;
          end else if (misaligned) begin
            o_faultM      = 1'b1;
            o_fault_codeM = FC_MISALIGN;
          end else begin
            state_d  = BUSY;
            cnt_d    = '0;
            addr_d   = i_alu_resultM;
            f3_d     = i_funct3M;
            wr_d     = i_ctrl_mem_wr_enM;
            be_d     = i_ctrl_mem_wr_enM ? st_be : 4'b1111;
            wdata_d  = i_ctrl_mem_wr_enM ? st_wdata : '0;
            o_stallM = 1'b1;
          end
        end
      end
      BUSY: begin
        if (i_dmem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!wr_q) begin
            rdata_d         = ld_data;
            o_mem_readdataM = ld_data;
          end
        end else if (timeout) begin
          state_d         = IDLE;
          cnt_d           = '0;
          o_faultM        = 1'b1;
          o_fault_codeM   = FC_TIMEOUT;
          o_mem_readdataM = '0;
          if (!wr_q) rdata_d = '0;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          o_stallM = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset forces the combinational strobes quiet even if an access is still presented.
    if (!i_rstn) begin
      o_stallM      = 1'b0;
      o_faultM      = 1'b0;
      o_fault_codeM = 2'b00;
    end
  end

  assign o_dmem_req     = (state_q == BUSY);
  assign o_dmem_wr      = wr_q;
  assign o_dmem_addr    = {addr_q[XW-1:2], 2'b00};
  assign o_dmem_wdata   = wdata_q;
  assign o_dmem_byte_en = be_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: table-driven and randomized checks of riscv_lsu against a behavioural access model.
module tb_riscv_lsu;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          lat;
    logic [1:0]  code;
    logic [3:0]  be;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] ldres;
  } vec_t;

  logic        clk, rstn;
  logic        rd_en, wr_en, ack;
  logic [2:0]  f3;
  logic [31:0] addr, rs2, rdata;
  logic        req, wr, stall, fault;
  logic [31:0] daddr, wdata, readdata;
  logic [3:0]  be;
  logic [1:0]  code;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] rd_model = 32'd0;

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_ctrl_mem_rd_enM(rd_en), .i_ctrl_mem_wr_enM(wr_en),
    .i_funct3M(f3), .i_alu_resultM(addr), .i_rs2_dataM(rs2),
    .o_dmem_req(req), .o_dmem_wr(wr), .o_dmem_addr(daddr),
    .o_dmem_wdata(wdata), .o_dmem_byte_en(be),
    .i_dmem_ack(ack), .i_dmem_rdata(rdata),
    .o_stallM(stall), .o_mem_readdataM(readdata),
    .o_faultM(fault), .o_fault_codeM(code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic r, input logic w, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] s, input logic [31:0] d,
                               input int l, input logic [1:0] c, input logic [3:0] b,
                               input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] lr);
    vec_t v;
    v.rd = r; v.wr = w; v.f3 = f; v.addr = a; v.rs2 = s; v.rdata = d; v.lat = l;
    v.code = c; v.be = b; v.waddr = wa; v.wdata = wd; v.ldres = lr;
    return v;
  endfunction

  // Reference: derive expectations from access size/offset arithmetic.
  function automatic vec_t model(input vec_t vi);
    vec_t   v;
    bit     legal;
    int     sz, off;
    longint w, val, span;
    v     = vi;
    off   = int'(v.addr % 4);
    sz    = 1 << int'(v.f3 % 4);
    legal = 1'b0;
    if (v.rd && v.wr)  legal = 1'b0;
    else if (v.rd)     legal = (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else if (v.wr)     legal = (v.f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal)                 v.code = 2'd2;
    else if ((off % sz) != 0)   v.code = 2'd1;
    else                        v.code = 2'd0;
    v.waddr = v.addr - 32'(off);
    if (v.wr) begin
      v.be = 4'(((1 << sz) - 1) << off);
      if (sz == 1)      v.wdata = (v.rs2 % 256) * 32'h0101_0101;
      else if (sz == 2) v.wdata = (v.rs2 % 65536) * 32'h0001_0001;
      else              v.wdata = v.rs2;
    end else begin
      v.be    = 4'hF;
      v.wdata = 32'd0;
    end
    w    = longint'(v.rdata);
    span = longint'(1) << (8 * sz);
    val  = (w >> (8 * off)) % span;
    if (v.f3 < 3'd4 && sz < 4 && val >= span / 2) val = val - span;
    v.ldres = 32'(val);
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    ack = 1'b0; rd_en = v.rd; wr_en = v.wr; f3 = v.f3; addr = v.addr; rs2 = v.rs2;
    #1;
    chk("accept_req_low", 32'(req), 32'd0);
    chk("accept_rdata_hold", readdata, rd_model);
    if (v.code != 2'd0) begin
      chk("fault_flag", 32'(fault), 32'd1);
      chk("fault_code", 32'(code), 32'(v.code));
      chk("fault_no_stall", 32'(stall), 32'd0);
    end else begin
      chk("accept_no_fault", 32'(fault), 32'd0);
      chk("accept_stall", 32'(stall), 32'd1);
      for (int k = 0; k <= v.lat; k++) begin
        step();
        ack   = (k == v.lat);
        rdata = ack ? v.rdata : $urandom;
        addr  = $urandom;
        rs2   = $urandom;
        f3    = 3'($urandom_range(0, 7));
        #1;
        chk("busy_req", 32'(req), 32'd1);
        chk("busy_wr", 32'(wr), 32'(v.wr));
        chk("busy_addr", daddr, v.waddr);
        chk("busy_be", 32'(be), 32'(v.be));
        if (v.wr) chk("busy_wdata", wdata, v.wdata);
        chk("busy_stall", 32'(stall), (k == v.lat) ? 32'd0 : 32'd1);
        chk("busy_no_fault", 32'(fault), 32'd0);
        if (k == v.lat) begin
          if (!v.wr) rd_model = v.ldres;
          chk("ack_readdata", readdata, rd_model);
        end
      end
    end
  endtask

  task automatic idle_gap();
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    ack   = 1'($urandom_range(0, 1));
    rdata = $urandom;
    #1;
    chk("idle_req", 32'(req), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_fault", 32'(fault), 32'd0);
    chk("idle_ack_ignored", readdata, rd_model);
  endtask

  vec_t tbl[15];

  initial begin
    rstn = 1'b0; rd_en = 1'b0; wr_en = 1'b0; ack = 1'b0;
    f3 = 3'd0; addr = 32'd0; rs2 = 32'd0; rdata = 32'd0;

    tbl[0]  = mkv(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 2'd0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF);
    tbl[1]  = mkv(0, 1, 3'b000, 32'h203, 32'hA5, 32'h0, 1, 2'd0, 4'h8, 32'h200, 32'hA5A5A5A5, 32'h0);
    tbl[2]  = mkv(1, 0, 3'b000, 32'h301, 32'h0, 32'h80FF7F01, 0, 2'd0, 4'hF, 32'h300, 32'h0, 32'h0000007F);
    tbl[3]  = mkv(1, 0, 3'b100, 32'h303, 32'h0, 32'h80FF7F01, 1, 2'd0, 4'hF, 32'h300, 32'h0, 32'h00000080);
    tbl[4]  = mkv(1, 0, 3'b001, 32'h302, 32'h0, 32'h80FF7F01, 0, 2'd0, 4'hF, 32'h300, 32'h0, 32'hFFFF80FF);
    tbl[5]  = mkv(1, 0, 3'b101, 32'h302, 32'h0, 32'h80FF7F01, 2, 2'd0, 4'hF, 32'h300, 32'h0, 32'h000080FF);
    tbl[6]  = mkv(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 2'd1, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[7]  = mkv(1, 1, 3'b010, 32'h104, 32'h0, 32'h0, 0, 2'd2, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[8]  = mkv(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1, 2'd0, 4'hC, 32'h200, 32'hABCDABCD, 32'h0);
    tbl[9]  = mkv(0, 1, 3'b001, 32'h201, 32'h0, 32'h0, 0, 2'd1, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[10] = mkv(1, 0, 3'b011, 32'h008, 32'h0, 32'h0, 0, 2'd2, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[11] = mkv(0, 1, 3'b100, 32'h000, 32'h0, 32'h0, 0, 2'd2, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[12] = mkv(1, 0, 3'b110, 32'h003, 32'h0, 32'h0, 0, 2'd2, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[13] = mkv(1, 0, 3'b010, 32'h010, 32'h0, 32'h0BADF00D, 0, 2'd0, 4'hF, 32'h010, 32'h0, 32'h0BADF00D);
    tbl[14] = mkv(0, 1, 3'b010, 32'h07C, 32'hCAFEBABE, 32'h0, 2, 2'd0, 4'hF, 32'h07C, 32'hCAFEBABE, 32'h0);

    repeat (2) step();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_addr", daddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_be", 32'(be), 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    step();
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step();
      run_txn(tbl[i]);
    end
    idle_gap();

    for (int n = 0; n < 300; n++) begin
      vec_t v;
      int   sel, p;
      sel  = $urandom_range(0, 9);
      v.rd = (sel <= 4) || (sel == 9);
      v.wr = (sel >= 5);
      if ($urandom_range(0, 1) == 1) v.f3 = 3'($urandom_range(0, 7));
      else if (v.wr)                 v.f3 = 3'($urandom_range(0, 2));
      else begin
        p    = $urandom_range(0, 4);
        v.f3 = 3'((p < 3) ? p : p + 1);
      end
      v.addr  = $urandom;
      v.rs2   = $urandom;
      v.rdata = $urandom;
      v.lat   = $urandom_range(0, 2);
      v = model(v);
      step();
      run_txn(v);
      if ($urandom_range(0, 3) == 0) idle_gap();
    end
    idle_gap();

    // Timeout: with TIMEOUT_CYCLES=4 and no ack, req spans 4 cycles and the 4th reports code 11.
    step();
    ack = 1'b0; rd_en = 1'b1; wr_en = 1'b0; f3 = 3'b010; addr = 32'h40;
    #1;
    chk("to_accept_stall", 32'(stall), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("to_req", 32'(req), 32'd1);
      if (k < 4) begin
        chk("to_wait_stall", 32'(stall), 32'd1);
        chk("to_wait_fault", 32'(fault), 32'd0);
      end else begin
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_code", 32'(code), 32'd3);
        chk("to_release_stall", 32'(stall), 32'd0);
        chk("to_readdata_zero", readdata, 32'd0);
      end
    end
    step();
    rd_en = 1'b0;
    #1;
    chk("to_after_req", 32'(req), 32'd0);
    chk("to_after_fault", 32'(fault), 32'd0);
    chk("to_after_stall", 32'(stall), 32'd0);

    // Reset during BUSY, then a stale ack after release.
    step();
    rd_en = 1'b1; f3 = 3'b010; addr = 32'h80;
    #1;
    chk("rb_accept_stall", 32'(stall), 32'd1);
    step();
    chk("rb_busy_req", 32'(req), 32'd1);
    #2 rstn = 1'b0;
    #1;
    rd_model = 32'd0;
    chk("rb_req_drop", 32'(req), 32'd0);
    chk("rb_stall_drop", 32'(stall), 32'd0);
    chk("rb_fault_drop", 32'(fault), 32'd0);
    step();
    rstn = 1'b1; rd_en = 1'b0;
    step();
    ack = 1'b1; rdata = 32'h12345678;
    #1;
    chk("rb_late_ack_req", 32'(req), 32'd0);
    chk("rb_late_ack_stall", 32'(stall), 32'd0);
    chk("rb_late_ack_data", readdata, 32'd0);
    step();
    ack = 1'b0;
    #1;
    chk("rb_data_after", readdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit for the pipelined RV32I core's memory stage. It sits between the execute/memory pipeline register and the writeback pipeline register. It turns execute-stage load/store controls into a request/acknowledge transaction on the data-memory port, and stalls the pipeline until that transaction completes. It also returns load data, already aligned and sign/zero-extended, as the memory read data consumed by the writeback stage.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles a request may wait for `i_dmem_ack` before it is aborted; range 1..255.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rstn  input  1  reset; asynchronous, active-low.
- i_ctrl_mem_rd_enM  input  1  instruction in the memory stage is a load.
- i_ctrl_mem_wr_enM  input  1  instruction in the memory stage is a store.
- i_funct3M  input  3  access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
- i_alu_resultM  input  `XLEN  byte address.
- i_rs2_dataM  input  `XLEN  store source data.
- o_dmem_req  output  1  request valid; held high until ack or timeout.
- o_dmem_wr  output  1  1 = write, 0 = read.
- o_dmem_addr  output  `XLEN  word address, {addr[31:2], 2'b00}.
- o_dmem_wdata  output  `XLEN  lane-replicated store data.
- o_dmem_byte_en  output  4  byte lane enables (writes); 4'b1111 on reads.
- i_dmem_ack  input  1  one-cycle completion strobe; `i_dmem_rdata` is valid with it.
- i_dmem_rdata  input  `XLEN  raw read word.
- o_stallM  output  1  hold the fetch/decode/execute/memory pipeline registers.
- o_mem_readdataM  output  `XLEN  extended load result.
- o_faultM  output  1  access fault for the current instruction.
- o_fault_codeM  output  2  01 misaligned, 10 illegal access, 11 bus timeout, 00 none.

## Operation
- FSM states: IDLE, BUSY.
- **IDLE, accepting an access**
  - An access is any of rd_en or wr_en.
  - If the access is legal and aligned, latch address, wdata, byte_en, funct3 and wr, then go to BUSY.
  - `o_stallM` = 1 in this cycle.
- **Illegal access** (no request, no stall, stay IDLE)
  - rd_en and wr_en both set.
  - Load funct3 of 011 or 11x.
  - Store funct3 other than 000/001/010.
  - Response: `o_faultM` = 1, code 10.
- **Misaligned access** (no request, no stall, stay IDLE)
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] ≠ 0.
  - Response: `o_faultM` = 1, code 01.
  - Illegal takes priority over misaligned.
- **BUSY**
  - `o_dmem_req` = 1 and the bus outputs come from the latched copies; inputs are ignored.
  - `o_stallM` = BUSY & ~i_dmem_ack & ~timeout.
  - On ack: go to IDLE and clear the counter.
- **Timeout counter**
  - 8-bit; counts BUSY cycles.
  - When it equals TIMEOUT_CYCLES−1 without ack: drop req, `o_faultM` = 1 with code 11 for that cycle, release the stall, read data = 0, go to IDLE.
- **Store formatting**
  - SB: byte_en = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: byte_en = 4'b0011 << {addr[1], 0}; wdata = {2{rs2[15:0]}}.
  - SW: byte_en = 4'b1111; wdata = rs2.
- **Load formatting**
  - Select byte/half from the raw word by latched addr[1:0].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- **o_mem_readdataM**
  - In the ack cycle: the formatted `i_dmem_rdata`, combinationally.
  - Otherwise: a register capturing that value on ack.
  - Stores leave the register unchanged.

## Timing
- Reset values:
  - state IDLE, counter 0, latched regs 0.
  - `o_dmem_req`, `o_dmem_wr`, `o_dmem_addr`, `o_dmem_wdata`, `o_dmem_byte_en` all 0.
  - `o_mem_readdataM` 0, `o_faultM`/code 0.
  - `o_stallM` 0 when no access is presented.
- Reset assertion mid-transaction drops `o_dmem_req` immediately (asynchronously); a late ack after reset is ignored.
- **Cycle sequence for a zero-wait-state memory** (ack in the first BUSY cycle):
  - Cycle 0: access presented in IDLE, stall = 1.
  - Cycle 1: req = 1, ack = 1, stall = 0.
  - The pipeline advances at the end of cycle 1, and the writeback register captures `o_mem_readdataM` at that edge.
- Total memory-stage occupancy is 1 + (ack latency) cycles.
- A new access can be accepted in the cycle directly after the ack; a back-to-back request therefore has exactly one req-low cycle between transactions.
- Ack while IDLE is ignored.
- Fault outputs are combinational and valid only in the cycle they are asserted.

## Test plan
- LW at 0x100, memory acks 2 cycles after req with 0xDEADBEEF:
  - Response: stall high for 3 cycles, then `o_mem_readdataM` = 0xDEADBEEF in the ack cycle and held afterwards.
  - Check: `o_dmem_addr` = 0x100, byte_en = 4'b1111.
- SB rs2 = 0x000000A5 at 0x203:
  - Response: addr 0x200, byte_en 4'b1000, wdata 0xA5A5A5A5, wr = 1.
  - Check: read data register unchanged.
- LB / LBU / LH / LHU at offsets 1/3/2/2 with rdata 0x80FF7F01:
  - Required results: 0x0000007F, 0x00000080, 0xFFFF80FF, 0x000080FF.
- LW at 0x102 → `o_faultM` = 1, code 01, no req, no stall.
- rd_en = wr_en = 1 → code 10.
- TIMEOUT_CYCLES = 4, never ack:
  - Response: req high for exactly 4 cycles, code 11 pulse on the 4th, stall released that cycle, then back to IDLE.
- Assert i_rstn low during BUSY:
  - Response: req, stall and fault outputs go to 0 before the next edge; an ack delivered after reset release leaves read data at 0.
